// File: rtl/aud_pkg.sv
// aud_pkg: constants and types shared by the audio player and recorder.
//   ADDR_W        SRAM word address width
//   DATA_W        sample width in bits
//   SPD_W         speed field width (factor = speed + 1)
//   BITS_PER_WORD serial bits per channel word
//   state_e       player/recorder FSM states
package aud_pkg;

  localparam int ADDR_W        = 20;
  localparam int DATA_W        = 16;
  localparam int SPD_W         = 3;
  localparam int BITS_PER_WORD = 16;
  localparam int CNT_W         = $clog2(BITS_PER_WORD + 1);
  localparam int IDX_W         = $clog2(BITS_PER_WORD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_PAUSE
  } state_e;

endpackage

// File: rtl/aud_player_if.sv
// aud_player_if: SRAM read-side bus between the player and the SRAM controller.
//   address    SRAM word address (player -> controller)
//   sram_data  read data, valid one BCLK falling edge after address changes
//   master     player side, slave: SRAM controller side
interface aud_player_if;
  import aud_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] sram_data;

  modport master (output address, input  sram_data);
  modport slave  (input  address, output sram_data);
endinterface

// File: rtl/aud_serializer.sv
// aud_serializer: 16-bit shift register plus bit counter for the DAC stream.
//   i_clk/i_rst_n  BCLK (falling-edge active) / async active-low reset
//   i_load         capture i_data; o_bit presents i_data[0] in the same cycle
//   i_step         advance to the next bit
//   i_abort        clear the bit counter (word abandoned or finished)
//   i_data         sample word, bit 0 transmitted first
//   o_bit          bit to be registered onto DACDAT this edge
//   o_last         all bits of the word have been sent
module aud_serializer
  import aud_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_bit,
  output logic              o_last
);

  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (i_abort) begin
      cnt_q   <= '0;
    end else if (i_load) begin
      shift_q <= i_data;
      cnt_q   <= CNT_W'(1);
    end else if (i_step) begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Bit 0 bypasses the register so it leaves on the loading edge.
  always_comb begin
    o_bit  = i_load ? i_data[0] : shift_q[cnt_q[IDX_W-1:0]];
    o_last = (cnt_q == CNT_W'(BITS_PER_WORD));
  end

endmodule

// File: rtl/aud_player.sv
// aud_player: SRAM-to-WM8731 DAC playback engine, falling-edge of BCLK.
//   i_clk        BCLK from codec
//   i_rst_n      asynchronous active-low reset
//   i_lrc        DACLRC (low = left, high = right)
//   i_start      start / resume request
//   i_pause      pause request
//   i_stop       stop request (beats pause)
//   i_fast       1 = skip addresses, 0 = repeat samples
//   i_speed      speed factor minus one
//   i_end_addr   last valid recorded address
//   sram         SRAM read bus (master)
//   o_dacdat     serial DAC data
//   o_playing    high while waiting for or shifting a word
//   o_done       one-cycle pulse when the recording end is reached
module aud_player
  import aud_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_fast,
  input  logic [SPD_W-1:0]  i_speed,
  input  logic [ADDR_W-1:0] i_end_addr,
  aud_player_if.master      sram,
  output logic              o_dacdat,
  output logic              o_playing,
  output logic              o_done
);

  localparam int AW1 = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SPD_W-1:0]  rep_q, rep_d;
  logic              dacdat_q, dacdat_d;
  logic              done_q, done_d;
  logic              right_q, right_d;
  logic              lrc_q;

  logic              lrc_edge;
  logic [AW1-1:0]    step_amt;
  logic [AW1-1:0]    next_addr;
  logic              ser_load, ser_step, ser_abort, ser_bit, ser_last;

  aud_serializer u_ser (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (ser_load),
    .i_step  (ser_step),
    .i_abort (ser_abort),
    .i_data  (sram.sram_data),
    .o_bit   (ser_bit),
    .o_last  (ser_last)
  );

  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rep_q    <= '0;
      dacdat_q <= 1'b0;
      done_q   <= 1'b0;
      right_q  <= 1'b0;
      lrc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rep_q    <= rep_d;
      dacdat_q <= dacdat_d;
      done_q   <= done_d;
      right_q  <= right_d;
      lrc_q    <= i_lrc;
    end
  end

  // Next address is one bit wider so the end compare cannot wrap.
  always_comb begin
    lrc_edge = i_lrc ^ lrc_q;
    if (i_fast)                 step_amt = AW1'(i_speed) + AW1'(1);
    else if (rep_q == i_speed)  step_amt = AW1'(1);
    else                        step_amt = '0;
    next_addr = {1'b0, addr_q} + step_amt;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rep_d     = rep_q;
    dacdat_d  = 1'b0;
    done_d    = 1'b0;
    right_d   = right_q;
    ser_load  = 1'b0;
    ser_step  = 1'b0;
    ser_abort = 1'b0;

    if (state_q == S_IDLE) begin
      if (i_start) begin
        state_d = S_WAIT;
        addr_d  = '0;
        rep_d   = '0;
      end
    end else if (i_stop) begin
      state_d   = S_IDLE;
      addr_d    = '0;
      rep_d     = '0;
      ser_abort = 1'b1;
    end else if (i_pause) begin
      state_d   = S_PAUSE;
      ser_abort = 1'b1;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (lrc_edge) begin
            ser_load = 1'b1;
            dacdat_d = ser_bit;
            right_d  = i_lrc;
            state_d  = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (ser_last) begin
            ser_abort = 1'b1;
            state_d   = S_WAIT;
            if (right_q) begin
              if (next_addr > {1'b0, i_end_addr}) begin
                state_d = S_IDLE;
                addr_d  = '0;
                rep_d   = '0;
                done_d  = 1'b1;
              end else begin
                addr_d = next_addr[ADDR_W-1:0];
                rep_d  = (i_fast || rep_q == i_speed) ? '0 : rep_q + 1'b1;
              end
            end
          end else begin
            ser_step = 1'b1;
            dacdat_d = ser_bit;
          end
        end
        S_PAUSE: begin
          if (i_start) state_d = S_WAIT;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign sram.address = addr_q;
  assign o_dacdat     = dacdat_q;
  assign o_done       = done_q;
  assign o_playing    = (state_q == S_WAIT) || (state_q == S_SHIFT);

endmodule
